// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Moore-style sequencer for the shared-memory, shared-ALU multi-cycle RV32I
//   datapath. Each instruction walks FETCH -> DECODE -> (execute / memory /
//   writeback) states and ends with a one-cycle InstrDone pulse.
//
// Ports
//   clk, rst           : clock, asynchronous active-high reset
//   opcode/funct3/funct7 : latched instruction fields (only funct7[5] used)
//   zero, neg          : ALU flags, used only for the branch decision
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite : datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc : datapath selects
//   InstrDone          : high in the last state of every instruction
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       InstrDone
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_JALR1    = 4'd10;
  localparam logic [3:0] S_JALR2    = 4'd11;
  localparam logic [3:0] S_BRANCH   = 4'd12;
  localparam logic [3:0] S_LUI      = 4'd13;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic [3:0] state_q, state_d;
  logic       pc_write, mem_write, ir_write, reg_write, instr_done;
  logic       branch_taken;

  // Only funct7[5] selects add/sub; the remaining bits are intentionally ignored.
  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Shared ALU-op table for register and immediate arithmetic; sub_en is
  // forced low for the immediate form since there is no subi.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
    case (f3)
      3'b000:  alu_decode = sub_en ? ALU_SUB : ALU_ADD;
      3'b111:  alu_decode = ALU_AND;
      3'b110:  alu_decode = ALU_OR;
      3'b010:  alu_decode = ALU_SLT;
      3'b100:  alu_decode = ALU_XOR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

  // Signed compare uses raw neg; overflow is not corrected.
  always_comb begin
    case (funct3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = neg;
      3'b101:  branch_taken = ~neg;
      default: branch_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    AdrSrc     = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    reg_write  = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_write  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for a later JAL or taken branch.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OP_STORE:  ImmSrc = IMM_S;
          OP_BRANCH: ImmSrc = IMM_B;
          OP_JAL:    ImmSrc = IMM_J;
          OP_LUI:    ImmSrc = IMM_U;
          default:   ImmSrc = IMM_I;
        endcase
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR1;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          default: begin
            // Unknown opcode retires as a no-op.
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_decode(funct3, funct7[5]);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(funct3, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // PC loads the target held in ALUOut while the ALU forms OldPC+4 for rd.
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR2;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pc_write   = branch_taken;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_LUI: begin
        ImmSrc     = IMM_U;
        ResultSrc  = 2'b11;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are masked for the whole reset interval, not just at the edge.
  assign PCWrite   = pc_write   & ~rst;
  assign MemWrite  = mem_write  & ~rst;
  assign IRWrite   = ir_write   & ~rst;
  assign RegWrite  = reg_write  & ~rst;
  assign InstrDone = instr_done & ~rst;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style finite state machine that sequences the shared-memory, shared-ALU multi-cycle RISC-V RV32I datapath. It replaces the single-cycle decode controller. Each instruction takes 3–5 cycles, driven through fetch, decode, execute, memory and writeback states. It decodes the latched instruction fields into datapath selects, ALU operations and write enables, and pulses `InstrDone` on each instruction's last cycle.

## Interface
- No parameters.
- `clk` in 1 — single clock; all state changes on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `opcode` in 7 — instruction register [6:0]; stable from DECODE onward.
- `funct3` in 3 — instruction register [14:12].
- `funct7` in 7 — instruction register [31:25]; only bit 5 is used.
- `zero` in 1 — ALU result == 0.
- `neg` in 1 — ALU result bit 31.
- `PCWrite` out 1 — PC register load enable.
- `AdrSrc` out 1 — memory address select: 0 = PC, 1 = Result.
- `MemWrite` out 1 — data memory write enable.
- `IRWrite` out 1 — load instruction register and OldPC.
- `ResultSrc` out 2 — 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt.
- `ALUSrcA` out 2 — 00 PC, 01 OldPC, 10 rs1 (A register).
- `ALUSrcB` out 2 — 00 rs2 (WriteData register), 01 ImmExt, 10 constant 4.
- `ALUControl` out 3 — 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor.
- `ImmSrc` out 3 — 000 I, 001 S, 010 B, 011 J, 100 U.
- `RegWrite` out 1 — register file write enable.
- `InstrDone` out 1 — high during the final state of each instruction.

## Operation
- Unlisted outputs in any state: enables 0, selects 0, `ALUControl`=add, `ImmSrc`=I.
- FETCH: AdrSrc=0, IRWrite=1, A=PC, B=4, add, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: A=OldPC, B=ImmExt, add. This precomputes the branch or JAL target into ALUOut. ImmSrc comes from opcode: S for 0100011, B for 1100011, J for 1101111, U for 0110111, else I. Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100111 → JALR1
  - 1100011 → BRANCH
  - 0110111 → LUI
  - any other opcode → FETCH with InstrDone=1 and no architectural writes.
- MEMADR: A=rs1, B=ImmExt, add, ImmSrc=S for stores and I for loads. Next state MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, InstrDone=1. Next state FETCH.
- EXECR: A=rs1, B=rs2. ALU op from funct3:
  - 000 → sub if funct7[5], else add
  - 111 → and; 110 → or; 010 → slt; 100 → xor
  - other funct3 → add
  - Next state ALUWB.
- EXECI: A=rs1, B=ImmExt, ImmSrc=I. Same ALU table as EXECR except funct3=000 is always add. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1. Next state FETCH.
- JAL: A=OldPC, B=4, add, ResultSrc=00, PCWrite=1. The PC takes the DECODE target. Next state ALUWB, which writes OldPC+4 to rd.
- JALR1: A=rs1, B=ImmExt, add. Next state JALR2.
- JALR2: A=OldPC, B=4, add, ResultSrc=00, PCWrite=1. Next state ALUWB.
- BRANCH: A=rs1, B=rs2, sub, ResultSrc=00, InstrDone=1. Next state FETCH.
  - PCWrite (combinational on flags): beq(000)=zero, bne(001)=!zero, blt(100)=neg, bge(101)=!neg.
  - Other funct3 values: never taken.
  - `neg` is used without an overflow correction.
- LUI: ImmSrc=U, ResultSrc=11, RegWrite=1, InstrDone=1. Next state FETCH.

## Timing
- Reset: while `rst`=1, state=FETCH and PCWrite, IRWrite, MemWrite, RegWrite and InstrDone are forced to 0. All other outputs hold their FETCH values.
- Reset asserted mid-instruction aborts it immediately. The first rising edge after `rst` falls executes FETCH.
- Cycles per instruction: lw 5, jalr 5, sw 4, R-type 4, I-type 4, jal 4, branch 3, lui 3, illegal 2.
- All outputs are functions of state and instruction fields only, except BRANCH PCWrite, which also depends on `zero`/`neg` in the same cycle.
- Exactly one InstrDone pulse per instruction; FETCH always follows it.

## Test plan
- Reset then release: cycle 0 is FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10; asserting `rst` mid-MEMREAD returns the FSM to FETCH with MemWrite=RegWrite=0.
- lw (opcode 0000011): 5 cycles; MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01, RegWrite=1, InstrDone=1.
- sw (opcode 0100011): 4 cycles; MEMADR has ImmSrc=001; MEMWRITE has MemWrite=1 and RegWrite=0.
- R-type sub (funct3=000, funct7=0100000): EXECR has ALUControl=001. addi with funct7[5]=1 gives ALUControl=000 in EXECI.
- Branch cases, each 3 cycles:
  - beq with zero=1 → PCWrite=1 in BRANCH.
  - bne with zero=1 → PCWrite=0.
  - blt with neg=1 → PCWrite=1.
  - bge with neg=1 → PCWrite=0.
- jal: JAL state has PCWrite=1, ALUSrcA=01, ALUSrcB=10. jalr: 5 cycles with JALR1 then JALR2. lui: LUI has ResultSrc=11, ImmSrc=100. Illegal opcode 1111111: DECODE → FETCH with no write enables asserted.
